// File: rtl/wavefront_feeder.sv
// rtl/wavefront_feeder.sv - skewed-operand scheduler feeding a diagonal systolic array
// Buffers per-lane weights and a shared ifmap, then streams phase P with lane k carrying element P-k.
module wavefront_feeder #(
  parameter int DW    = 16,
  parameter int DIM   = 16,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DIM),
  parameter int AW    = $clog2(DEPTH),
  parameter int PW    = $clog2(DEPTH + DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW:0]       cfg_num_iter,
  input  logic              cfg_bcast,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [LW-1:0]     wr_lane,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW*DIM-1:0] weight_out,
  output logic [DW*DIM-1:0] ifmap_out,
  output logic [DIM-1:0]    lane_valid,
  output logic [PW-1:0]     phase
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FIN    = 2'd2;

  logic [1:0]    state;
  logic [AW:0]   n_q;
  logic          bcast_q;
  logic [AW:0]   n_clamp;
  logic [PW-1:0] last_phase;
  logic          streaming;

  logic [DW-1:0] wbuf [DIM][DEPTH];
  logic [DW-1:0] ibuf [DEPTH];

  assign n_clamp    = (cfg_num_iter > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_num_iter;
  assign last_phase = PW'(n_q) + PW'(DIM - 2);
  assign streaming  = (state == S_STREAM);
  assign busy       = streaming;
  assign out_valid  = streaming;

  // Buffers have no reset so their contents survive a mid-stream reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      if (wr_sel) begin
        ibuf[wr_addr] <= wr_data;
      end else begin
        for (int k = 0; k < DIM; k++) begin
          if (wr_lane == LW'(k)) wbuf[k][wr_addr] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      done    <= 1'b0;
      n_q     <= '0;
      bcast_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q     <= n_clamp;
            bcast_q <= cfg_bcast;
            phase   <= '0;
            state   <= (n_clamp == '0) ? S_FIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            phase <= phase + 1'b1;
            if (phase == last_phase) state <= S_FIN;
          end
        end
        S_FIN: begin
          // done is registered, so it lands the cycle after FIN
          done  <= 1'b1;
          phase <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DIM; k++) begin : g_lane
    logic [PW:0] dk;
    assign dk = {1'b0, phase} - (PW+1)'(k);
    assign lane_valid[k] = streaming && !dk[PW] && (dk < (PW+1)'(n_q));
    assign weight_out[k*DW +: DW] = lane_valid[k] ? wbuf[k][dk[AW-1:0]] : '0;
    if (k == 0) begin : g_lane0
      assign ifmap_out[DW-1:0] = lane_valid[0] ? ibuf[dk[AW-1:0]] : '0;
    end else begin : g_lanek
      assign ifmap_out[k*DW +: DW] = (bcast_q && lane_valid[k]) ? ibuf[dk[AW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_wavefront_feeder.sv
// tb/tb_wavefront_feeder.sv - self-checking bench for wavefront_feeder
// Reference model derives each phase from the element-index rule P-k over shadow copies of the buffers.
module tb_wavefront_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   cfg_num_iter;
  logic         cfg_bcast;
  logic         wr_en;
  logic         wr_sel;
  logic [3:0]   wr_lane;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         start;
  logic         busy;
  logic         done;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] weight_out;
  logic [255:0] ifmap_out;
  logic [15:0]  lane_valid;
  logic [4:0]   phase;

  int passes = 0;
  int checks = 0;

  logic [15:0] mw [16][16];
  logic [15:0] mi [16];

  always #5 clk = ~clk;

  wavefront_feeder dut (
    .clk(clk), .rst_n(rst_n), .cfg_num_iter(cfg_num_iter), .cfg_bcast(cfg_bcast),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .weight_out(weight_out), .ifmap_out(ifmap_out), .lane_valid(lane_valid), .phase(phase)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input bit sel, input int lane, input int addr, input logic [15:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_lane = 4'(lane); wr_addr = 4'(addr); wr_data = data;
    if (sel) mi[addr] = data;
    else mw[lane][addr] = data;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic model(input int p, input int n, input bit bc,
                       output logic [15:0] lv, output logic [255:0] w, output logic [255:0] i);
    lv = '0; w = '0; i = '0;
    for (int k = 0; k < 16; k++) begin
      int d = p - k;
      if (d >= 0 && d < n) begin
        lv[k] = 1'b1;
        w[k*16 +: 16] = mw[k][d];
        if (bc || k == 0) i[k*16 +: 16] = mi[d];
      end
    end
  endtask

  task automatic run(input int cfg, input bit bc, input int stall_ph, input int stall_len,
                     input bit rnd, input int inj_ph, input int rst_ph,
                     output int acc, output int lat, output int stalls);
    int n, cyc, stall_cnt;
    bit got_done, injected;
    longint mac [16];
    logic [15:0] hist [64];
    logic [15:0] elv, snap_lv;
    logic [255:0] ew, ei, snap_w, snap_i;
    n = (cfg > 16) ? 16 : cfg;
    for (int k = 0; k < 16; k++) mac[k] = 0;
    acc = 0; lat = 0; stalls = 0; cyc = 0; stall_cnt = 0; got_done = 0; injected = 0;
    snap_lv = '0; snap_w = '0; snap_i = '0;
    @(negedge clk);
    cfg_num_iter = 5'(cfg); cfg_bcast = bc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got_done && cyc < 300) begin
      cyc++;
      wr_en = 1'b0; start = 1'b0;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(acc == stall_ph && stall_cnt < stall_len);
      #1;
      if (done) begin
        got_done = 1; lat = cyc;
      end else if (out_valid) begin
        if (acc == rst_ph) begin
          rst_n = 1'b0;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_valid", out_valid, 0);
          chk("rst_phase", phase, 0);
          @(negedge clk);
          rst_n = 1'b1;
          lat = -1;
          return;
        end
        model(acc, n, bc, elv, ew, ei);
        chk("phase", phase, acc);
        chk("lane_valid", lane_valid, elv);
        chk("weight", weight_out, ew);
        chk("ifmap", ifmap_out, ei);
        if (!out_ready) begin
          stalls++;
          if (!rnd) begin
            if (stall_cnt == 0) begin
              snap_lv = lane_valid; snap_w = weight_out; snap_i = ifmap_out;
            end else begin
              chk("stall_lv", lane_valid, snap_lv);
              chk("stall_w", weight_out, snap_w);
              chk("stall_i", ifmap_out, snap_i);
            end
            stall_cnt++;
          end
        end else begin
          hist[acc] = ifmap_out[15:0];
          for (int k = 0; k < 16; k++) begin
            if (lane_valid[k]) begin
              logic [15:0] iv;
              iv = bc ? ifmap_out[k*16 +: 16] : hist[acc-k];
              mac[k] += longint'(weight_out[k*16 +: 16]) * longint'(iv);
            end
          end
          acc++;
        end
        if (acc == inj_ph && !injected) begin
          injected = 1;
          wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 4'd0; wr_addr = 4'd0; wr_data = 16'hdead;
          start = 1'b1;
        end
      end
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    chk("done_seen", got_done, 1);
    #1 chk("done_pulse_width", done, 0);
    if (n > 0 && acc == n + 15) begin
      for (int k = 0; k < 16; k++) begin
        longint e = 0;
        for (int j = 0; j < n; j++) e += longint'(mw[k][j]) * longint'(mi[j]);
        chk("mac", 256'(mac[k]), 256'(e));
      end
    end
  endtask

  initial begin
    int acc, lat, st, lat1, cfg;
    bit bc;
    rst_n = 1'b0; cfg_num_iter = '0; cfg_bcast = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_lane = '0; wr_addr = '0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_phase", phase, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 16; j++) wr(0, k, j, 16'(k + 1));
    for (int j = 0; j < 16; j++) wr(1, 0, j, 16'(j + 1));

    run(3, 0, -1, 0, 0, -1, -1, acc, lat1, st);
    chk("s1_accepted", acc, 18);
    chk("s1_latency", lat1, 20);

    run(3, 1, -1, 0, 0, -1, -1, acc, lat, st);
    chk("s2_accepted", acc, 18);
    chk("s2_latency", lat, 20);

    run(3, 0, 5, 4, 0, -1, -1, acc, lat, st);
    chk("s3_accepted", acc, 18);
    chk("s3_latency", lat, lat1 + 4);

    run(0, 0, -1, 0, 0, -1, -1, acc, lat, st);
    chk("n0_accepted", acc, 0);
    chk("n0_latency", lat, 2);

    run(17, 0, -1, 0, 0, -1, -1, acc, lat, st);
    chk("nmax_accepted", acc, 31);
    chk("nmax_latency", lat, 33);

    run(3, 0, -1, 0, 0, 4, -1, acc, lat, st);
    chk("s5_accepted", acc, 18);
    chk("s5_latency", lat, 20);
    run(3, 0, -1, 0, 0, -1, -1, acc, lat, st);
    chk("s5_rerun_latency", lat, 20);

    run(3, 0, -1, 0, 0, -1, 7, acc, lat, st);
    chk("s6_aborted_at", acc, 7);
    run(3, 0, -1, 0, 0, -1, -1, acc, lat, st);
    chk("s6_restart_accepted", acc, 18);
    chk("s6_restart_latency", lat, 20);

    repeat (4) begin
      repeat (8) wr($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), 16'($urandom));
      cfg = $urandom_range(0, 17);
      bc = 1'($urandom_range(0, 1));
      run(cfg, bc, -1, 0, 1, -1, -1, acc, lat, st);
      if (cfg == 0) begin
        chk("rnd_accepted", acc, 0);
        chk("rnd_latency", lat, 2);
      end else begin
        chk("rnd_accepted", acc, ((cfg > 16) ? 16 : cfg) + 15);
        chk("rnd_latency", lat, ((cfg > 16) ? 16 : cfg) + 17 + st);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
